difftest_csr_snapshot: RTL and testbench

//  Captures the architectural CSR file at every retiring instruction and queues the snapshot.

---
 rtl/difftest_pkg.sv | 47 ++++
 rtl/difftest_sync_fifo.sv | 57 +++++
 rtl/difftest_csr_snapshot.sv | 82 ++++++++
 tb/tb_difftest_csr_snapshot.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared difftest types and constants: CSR bus layout, privilege encodings and the snapshot entry format.
// No logic; imported by the CSR snapshot queue and its FIFO.
package difftest_pkg;

  localparam int XLEN    = 64;
  localparam int CSR_NUM = 17;
  localparam int BUS_W   = XLEN * CSR_NUM;
  localparam int SEQ_W   = 32;

  localparam int CSR_MSTATUS  = 0;
  localparam int CSR_MEPC     = 1;
  localparam int CSR_SEPC     = 2;
  localparam int CSR_MTVAL    = 3;
  localparam int CSR_STVAL    = 4;
  localparam int CSR_MTVEC    = 5;
  localparam int CSR_STVEC    = 6;
  localparam int CSR_MCAUSE   = 7;
  localparam int CSR_SCAUSE   = 8;
  localparam int CSR_SATP     = 9;
  localparam int CSR_MIP      = 10;
  localparam int CSR_MIE      = 11;
  localparam int CSR_MSCRATCH = 12;
  localparam int CSR_SSCRATCH = 13;
  localparam int CSR_MIDELEG  = 14;
  localparam int CSR_MEDELEG  = 15;
  localparam int CSR_SPARE    = 16;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [XLEN-1:0] SSTATUS_MASK_DEF = 64'h8000_0003_000D_E762;

  typedef struct packed {
    logic [XLEN-1:0]  priv;
    logic [XLEN-1:0]  sstatus;
    logic [BUS_W-1:0] bus;
    logic [SEQ_W-1:0] seq;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);

  function automatic logic [XLEN-1:0] csr_field(input logic [BUS_W-1:0] bus, input int idx);
    return bus[idx*XLEN +: XLEN];
  endfunction

endpackage

// File: rtl/difftest_sync_fifo.sv
// Synchronous FIFO, 1-cycle write-to-read; push is dropped when full unless a pop frees the slot this cycle.
// Also reports the head that will be current after this edge so the owner can register its outputs.
module difftest_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             nxt_vld_o,
  output logic [WIDTH-1:0] nxt_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d, count_pop;
  logic             do_push, do_pop;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign do_pop   = pop_i & ~empty_o;
  assign do_push  = push_i & (~full_o | do_pop);

  assign wr_ptr_d  = wr_ptr_q + AW'(do_push);
  assign rd_ptr_d  = rd_ptr_q + AW'(do_pop);
  assign count_pop = count_q - (AW+1)'(do_pop);
  assign count_d   = count_pop + (AW+1)'(do_push);

  // An entry pushed into a queue that drains to empty becomes the head directly.
  assign nxt_vld_o = (count_d != '0);
  assign nxt_dat_o = (count_pop == '0) ? wdat_i : mem_q[rd_ptr_d];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdat_i;
    end
  end

endmodule

// File: rtl/difftest_csr_snapshot.sv
// Queues a CSR snapshot per retiring instruction for difftest export; snapshot visible one cycle after commit.
// commit_ready drops when the queue is full and no pop is in progress; commits offered while not ready are dropped and flagged.
module difftest_csr_snapshot
  import difftest_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] SSTATUS_M = SSTATUS_MASK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [1:0]        priv_mode,
  input  logic [BUS_W-1:0]  csr_bus,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic [XLEN-1:0]   snap_priv,
  output logic [XLEN-1:0]   snap_sstatus,
  output logic [BUS_W-1:0]  snap_bus,
  output logic [SEQ_W-1:0]  snap_seq,
  output logic              ovf_err
);

  snap_t            push_dat, nxt_dat, snap_q;
  logic             full, empty, nxt_vld, push, pop;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;

  // snap_valid decodes the registered occupancy, so no commit_valid path reaches it.
  assign snap_valid   = ~empty;
  assign pop          = snap_valid & snap_ready;
  assign commit_ready = ~full | pop;
  assign push         = commit_valid & commit_ready;

  assign seq_d = seq_q + SEQ_W'(push);
  assign ovf_d = ovf_q | (commit_valid & ~commit_ready);

  always_comb begin
    push_dat         = '0;
    push_dat.priv    = {{(XLEN-2){1'b0}}, priv_mode};
    push_dat.sstatus = csr_field(csr_bus, CSR_MSTATUS) & SSTATUS_M;
    push_dat.bus     = csr_bus;
    push_dat.seq     = seq_q;
  end

  difftest_sync_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .wdat_i    (push_dat),
    .pop_i     (pop),
    .full_o    (full),
    .empty_o   (empty),
    .nxt_vld_o (nxt_vld),
    .nxt_dat_o (nxt_dat)
  );

  // Output registers keep the last head once the queue drains, never exposing unwritten storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      snap_q <= '0;
    end else begin
      seq_q <= seq_d;
      ovf_q <= ovf_d;
      if (nxt_vld) begin
        snap_q <= nxt_dat;
      end
    end
  end

  assign snap_priv    = snap_q.priv;
  assign snap_sstatus = snap_q.sstatus;
  assign snap_bus     = snap_q.bus;
  assign snap_seq     = snap_q.seq;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_difftest_csr_snapshot.sv
// Scoreboard bench for difftest_csr_snapshot: a queue model predicts acceptance and snapshot contents,
// a negedge monitor compares every DUT output against it.
module tb_difftest_csr_snapshot;

  localparam int          DEPTH = 4;
  localparam logic [63:0] SMASK = 64'h8000_0003_000D_E762;

  typedef struct {
    logic [63:0]   priv;
    logic [63:0]   sstatus;
    logic [1087:0] bus;
    logic [31:0]   seq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          commit_valid;
  logic          commit_ready;
  logic [1:0]    priv_mode;
  logic [1087:0] csr_bus;
  logic          snap_valid;
  logic          snap_ready;
  logic [63:0]   snap_priv;
  logic [63:0]   snap_sstatus;
  logic [1087:0] snap_bus;
  logic [31:0]   snap_seq;
  logic          ovf_err;

  difftest_csr_snapshot dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .priv_mode    (priv_mode),
    .csr_bus      (csr_bus),
    .snap_valid   (snap_valid),
    .snap_ready   (snap_ready),
    .snap_priv    (snap_priv),
    .snap_sstatus (snap_sstatus),
    .snap_bus     (snap_bus),
    .snap_seq     (snap_seq),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  exp_t        last;
  logic [31:0] m_seq;
  logic        m_ovf;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_snap(input string tag, input exp_t e);
    int k;
    k = 0;
    for (int i = 0; i < 17; i++) begin
      if (snap_bus[i*64 +: 64] !== e.bus[i*64 +: 64]) begin
        k = i;
        break;
      end
    end
    chk({tag, ".priv"},    snap_priv,    e.priv);
    chk({tag, ".sstatus"}, snap_sstatus, e.sstatus);
    chk({tag, ".seq"},     {32'd0, snap_seq}, {32'd0, e.seq});
    chk($sformatf("%s.bus[%0d]", tag, k), snap_bus[k*64 +: 64], e.bus[k*64 +: 64]);
  endtask

  // Model: a commit is taken whenever the queue (after this cycle's pop) has room.
  always @(posedge clk) begin
    if (rst_n && commit_valid) begin
      if (q.size() != DEPTH) begin
        exp_t e;
        e.priv    = {62'd0, priv_mode};
        e.sstatus = csr_bus[63:0] & SMASK;
        e.bus     = csr_bus;
        e.seq     = m_seq;
        q.push_back(e);
        m_seq = m_seq + 32'd1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic exp_v, exp_r;
    exp_v = (q.size() != 0);
    exp_r = (q.size() != DEPTH) || (exp_v && snap_ready);
    chk("snap_valid",   {63'd0, snap_valid},   {63'd0, exp_v});
    chk("commit_ready", {63'd0, commit_ready}, {63'd0, exp_r});
    chk("ovf_err",      {63'd0, ovf_err},      {63'd0, m_ovf});
    if (exp_v) cmp_snap("head", q[0]);
    else       cmp_snap("hold", last);
    if (exp_v && snap_ready) last = q.pop_front();
  end

  function automatic logic [1087:0] rand_bus();
    logic [1087:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i*64 +: 64] = {$urandom(), $urandom()};
    return b;
  endfunction

  function automatic logic [1:0] rand_priv();
    logic [1:0] tbl [3];
    tbl[0] = 2'd0; tbl[1] = 2'd1; tbl[2] = 2'd3;
    return tbl[$urandom_range(0, 2)];
  endfunction

  task automatic model_clear();
    q.delete();
    m_seq = 32'd0;
    m_ovf = 1'b0;
    last  = '{priv: 64'd0, sstatus: 64'd0, bus: '0, seq: 32'd0};
  endtask

  task automatic drive_x(input logic cv, input logic sr, input logic [1:0] pm, input logic [1087:0] b);
    commit_valid = cv;
    snap_ready   = sr;
    priv_mode    = pm;
    csr_bus      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic sr);
    drive_x(cv, sr, rand_priv(), rand_bus());
  endtask

  task automatic idle_drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
  endtask

  initial begin
    logic [1087:0] b;
    model_clear();
    rst_n        = 1'b0;
    commit_valid = 1'b0;
    snap_ready   = 1'b0;
    priv_mode    = 2'd0;
    csr_bus      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0);

    // single commit, M-mode, known mstatus
    b = rand_bus();
    b[63:0] = 64'hA_0000_1888;
    drive_x(1'b1, 1'b0, 2'd3, b);
    drive(1'b0, 1'b0);
    idle_drain(3);

    // fill to full, core holds the fifth, then push+pop at full twice, then overflow
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    idle_drain(6);

    for (int i = 0; i < 200; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle_drain(6);

    // async reset with three entries queued
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    commit_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_async.snap_valid",   {63'd0, snap_valid},   64'd0);
    chk("rst_async.commit_ready", {63'd0, commit_ready}, 64'd1);
    chk("rst_async.snap_seq",     {32'd0, snap_seq},     64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    idle_drain(4);

    // sequence counter wrap
    force dut.seq_q = 32'hFFFF_FFFF;
    m_seq = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0);
    release dut.seq_q;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    idle_drain(4);

    for (int i = 0; i < 200; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    idle_drain(8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
